inst_mem_boot_ctrl: RTL and testbench
=====================================

# inst_mem_boot_ctrl

Boot-load controller for the byte-cell instruction memory. Accepts a byte-serial program stream, packs 4 bytes big-endian into 32-bit words, and drives the memory word write port at consecutive word-aligned addresses from 0. While loading it holds the pipeline's fetch stage frozen. On completion it pulses a PC restart so execution begins at address 0.

## Interface
- WORD_SIZE, 32, instruction word width (fixed 4 × MEM_CELL_SIZE)
- MEM_SIZE, 1024, instruction memory size in byte cells; ADDR_W = $clog2(MEM_SIZE) = 10
- MEM_CELL_SIZE, 8, bits per memory cell / per stream byte
- LEN_W (derived), ADDR_W-1 = 9, word-count width; MAX_WORDS = MEM_SIZE/4 = 256
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  load request; sampled only in IDLE or RUN
- load_len  in  LEN_W  number of words to load; sampled with start
- byte_valid  in  1  stream byte present
- byte_data  in  MEM_CELL_SIZE  stream byte
- byte_ready  out  1  controller accepts byte this cycle
- mem_we  out  1  one-cycle word write strobe
- mem_addr  out  ADDR_W  byte address of word written (low 2 bits always 0)
- mem_wdata  out  WORD_SIZE  packed word
- fetch_stall  out  1  freeze PC / IF stage
- pc_reset  out  1  one-cycle pulse: restart PC at 0
- done  out  1  level; last load completed successfully
- err  out  1  sticky; last start rejected
- words_loaded  out  LEN_W  words written in current/last load

## Operation
- States: IDLE, LOAD, WRITE, FINISH, RUN.
- IDLE (post-reset): pass-through; fetch_stall=0, byte_ready=0.
- IDLE/RUN + start: if load_len > MAX_WORDS -> err=1, done=0, state unchanged. If load_len == 0 -> err=0, done=0, go FINISH. Otherwise: err=0, done=0, words_loaded=0, byte index=0, go LOAD.
- LOAD: byte_ready=1, fetch_stall=1. A byte is accepted on valid&&ready. Byte index 0..3 lands in mem_wdata bits [31:24],[23:16],[15:8],[7:0] respectively (address+0 is the MSB). Acceptance of index 3 -> WRITE.
- WRITE (1 cycle): mem_we=1, mem_addr={words_loaded,2'b00}, byte_ready=0, fetch_stall=1. Next cycle words_loaded increments. If the incremented count == load_len -> FINISH, else LOAD with index 0.
- FINISH (1 cycle): pc_reset=1, fetch_stall=1, then RUN.
- RUN: done=1, fetch_stall=0, byte_ready=0. A new start reloads, as from IDLE.
- start in LOAD/WRITE/FINISH: ignored. Bytes offered outside LOAD: not accepted.
- mem_wdata and mem_addr hold their last values outside WRITE. Only mem_we qualifies them.

## Timing
- Reset (rst=0, async): state IDLE; all outputs 0, including mem_wdata, mem_addr, words_loaded, err, done.
- Reset mid-load: immediate return to IDLE. The partial word is discarded; words already written stay in memory; no pc_reset.
- Minimum cost is 5 cycles per word (4 accepts + 1 write), plus 1 FINISH cycle. Gaps on byte_valid stretch LOAD only.
- start accepted at edge N -> byte_ready=1 from cycle N+1.
- pc_reset is high exactly one cycle, immediately before done rises. fetch_stall falls in the same cycle done rises.
- Full load (load_len=256): last write addr 0x3FC; words_loaded=256 is representable (9 bits); no wrap.

## Test plan
- Reset then idle: release rst, hold start=0 10 cycles -> all outputs 0, byte_ready=0.
- Two-word load: start, load_len=2, stream 80 20 00 0A 04 40 08 00 with valid held -> mem_we at addr 0x000 data 0x8020000A, then addr 0x004 data 0x04400800. Writes are 5 cycles apart; pc_reset for 1 cycle, then done=1, fetch_stall=0, words_loaded=2.
- Throttled stream: same data with byte_valid toggling 1/0 -> identical writes, and no byte accepted while in WRITE.
- Bad length: start with load_len=257 from IDLE -> err=1, state stays IDLE, no mem_we. Then start, load_len=0 -> err=0, pc_reset pulse, done=1, no mem_we.
- Reset mid-load: after 6 bytes of a 3-word load, assert rst -> exactly one write (addr 0) seen, outputs 0, IDLE. A subsequent full load succeeds.
- Reload from RUN: after done, start load_len=1, bytes 10 20 30 40 -> done drops, fetch_stall=1, write addr 0 data 0x10203040, pc_reset, done=1.

Source files
------------

// File: rtl/inst_mem_boot_ctrl.sv
// Boot-load controller for the byte-cell instruction memory.
// Packs a byte stream big-endian into words, writes them at consecutive
// word addresses from 0, freezes fetch while loading, then pulses a PC restart.
module inst_mem_boot_ctrl #(
   parameter int WORD_SIZE      = 32,
   parameter int MEM_SIZE       = 1024,
   parameter int MEM_CELL_SIZE  = 8,
   localparam int ADDR_W        = $clog2(MEM_SIZE),
   localparam int LEN_W         = ADDR_W - 1,
   localparam int MAX_WORDS     = MEM_SIZE / 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         load_len,
   input  logic                     byte_valid,
   input  logic [MEM_CELL_SIZE-1:0] byte_data,
   output logic                     byte_ready,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [WORD_SIZE-1:0]     mem_wdata,
   output logic                     fetch_stall,
   output logic                     pc_reset,
   output logic                     done,
   output logic                     err,
   output logic [LEN_W-1:0]         words_loaded
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      WRITE  = 3'd2,
      FINISH = 3'd3,
      RUN    = 3'd4
   } state_t;

   // First three bytes of a word are staged here; the fourth completes it.
   localparam int PACK_W = WORD_SIZE - MEM_CELL_SIZE;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [1:0]              idx_r;
   logic [PACK_W-1:0]       pack_r;
   logic [LEN_W-1:0]        len_r;
   logic [LEN_W-1:0]        words_loaded_r;
   logic [LEN_W-1:0]        wl_inc_s;
   logic [WORD_SIZE-1:0]    mem_wdata_r;
   logic [ADDR_W-1:0]       mem_addr_r;
   logic                    mem_we_r;
   logic                    byte_ready_r;
   logic                    fetch_stall_r;
   logic                    pc_reset_r;
   logic                    done_r;
   logic                    err_r;
   logic                    start_ok_s;
   logic                    start_zero_s;
   logic                    start_bad_s;
   logic                    byte_acc_s;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and start/byte qualification.
   always_comb begin
      state_nxt_s  = state_r;
      start_ok_s   = 1'b0;
      start_zero_s = 1'b0;
      start_bad_s  = 1'b0;
      byte_acc_s   = 1'b0;
      wl_inc_s     = words_loaded_r + LEN_W'(1);
      case (state_r)
         IDLE, RUN: begin
            if (start) begin
               if (load_len > MAX_LEN) begin
                  start_bad_s = 1'b1;
               end else if (load_len == LEN_W'(0)) begin
                  start_zero_s = 1'b1;
                  state_nxt_s  = FINISH;
               end else begin
                  start_ok_s  = 1'b1;
                  state_nxt_s = LOAD;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         LOAD: begin
            if (byte_valid && byte_ready_r) begin
               byte_acc_s = 1'b1;
               if (idx_r == 2'd3) begin
                  state_nxt_s = WRITE;
               end else begin
                  state_nxt_s = LOAD;
               end
            end else begin
               state_nxt_s = LOAD;
            end
         end
         WRITE: begin
            if (wl_inc_s == len_r) begin
               state_nxt_s = FINISH;
            end else begin
               state_nxt_s = LOAD;
            end
         end
         FINISH: begin
            state_nxt_s = RUN;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Registered control outputs, decoded from the upcoming state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_ready_r  <= 1'b0;
         fetch_stall_r <= 1'b0;
         mem_we_r      <= 1'b0;
         pc_reset_r    <= 1'b0;
      end else begin
         byte_ready_r  <= (state_nxt_s == LOAD);
         fetch_stall_r <= (state_nxt_s == LOAD) || (state_nxt_s == WRITE) ||
                          (state_nxt_s == FINISH);
         mem_we_r      <= (state_nxt_s == WRITE);
         pc_reset_r    <= (state_nxt_s == FINISH);
      end
   end

   // Status flags: err records the last start decision, done marks a completed load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_r  <= 1'b0;
         done_r <= 1'b0;
      end else if (start_bad_s) begin
         err_r  <= 1'b1;
         done_r <= 1'b0;
      end else if (start_ok_s || start_zero_s) begin
         err_r  <= 1'b0;
         done_r <= 1'b0;
      end else if (state_r == FINISH) begin
         done_r <= 1'b1;
      end
   end

   // Byte packing, word count and write port; address/data hold outside WRITE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_r          <= 2'd0;
         pack_r         <= '0;
         len_r          <= '0;
         words_loaded_r <= '0;
         mem_wdata_r    <= '0;
         mem_addr_r     <= '0;
      end else if (start_ok_s) begin
         idx_r          <= 2'd0;
         len_r          <= load_len;
         words_loaded_r <= '0;
      end else if (byte_acc_s) begin
         idx_r <= idx_r + 2'd1;
         if (idx_r == 2'd3) begin
            mem_wdata_r <= {pack_r, byte_data};
            mem_addr_r  <= {words_loaded_r[LEN_W-2:0], 2'b00};
         end else begin
            pack_r <= {pack_r[PACK_W-MEM_CELL_SIZE-1:0], byte_data};
         end
      end else if (state_r == WRITE) begin
         idx_r          <= 2'd0;
         words_loaded_r <= wl_inc_s;
      end
   end

   assign byte_ready   = byte_ready_r;
   assign mem_we       = mem_we_r;
   assign mem_addr     = mem_addr_r;
   assign mem_wdata    = mem_wdata_r;
   assign fetch_stall  = fetch_stall_r;
   assign pc_reset     = pc_reset_r;
   assign done         = done_r;
   assign err          = err_r;
   assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_inst_mem_boot_ctrl.sv
// Self-checking bench for inst_mem_boot_ctrl: a cycle-by-cycle vector table
// for the two-word load, plus hand-written sequences for multi-cycle cases.
module tb_inst_mem_boot_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [8:0]  load_len;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        fetch_stall;
   logic        pc_reset;
   logic        done;
   logic        err;
   logic [8:0]  words_loaded;

   int n_vec  = 0;
   int n_fail = 0;

   logic [9:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          pcr_cnt    = 0;
   int          we_rdy_cnt = 0;

   typedef struct {
      logic        start;
      logic [8:0]  len;
      logic        bv;
      logic [7:0]  bd;
      logic        ready;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic        stall;
      logic        pcr;
      logic        done;
      logic        err;
      logic [8:0]  wl;
   } vec_t;

   vec_t tbl[14];

   inst_mem_boot_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .load_len     (load_len),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .fetch_stall  (fetch_stall),
      .pc_reset     (pc_reset),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write/pulse monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
         if (byte_ready) we_rdy_cnt++;
      end
      if (pc_reset) pcr_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] outs();
      return {7'd0, byte_ready, mem_we, mem_addr, mem_wdata, fetch_stall,
              pc_reset, done, err, words_loaded};
   endfunction

   function automatic logic [63:0] exp_of(input vec_t v);
      return {7'd0, v.ready, v.we, v.addr, v.wdata, v.stall, v.pcr, v.done,
              v.err, v.wl};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic clear_mon();
      #1;
      wr_addr_q.delete();
      wr_data_q.delete();
      pcr_cnt    = 0;
      we_rdy_cnt = 0;
   endtask

   task automatic do_start(input logic [8:0] len);
      start    = 1'b1;
      load_len = len;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic send_bytes(input logic [7:0] bytes[$], input bit throttle, input int budget);
      int i = 0;
      int cyc = 0;
      bit ph = 1'b1;
      bit acc;
      while (i < bytes.size() && cyc < budget) begin
         byte_data  = bytes[i];
         byte_valid = throttle ? ph : 1'b1;
         ph         = ~ph;
         acc        = byte_valid && byte_ready;
         @(negedge clk);
         cyc++;
         if (acc) i++;
      end
      byte_valid = 1'b0;
      check("bytes_sent", 64'(i), 64'(bytes.size()));
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (!done && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("done_wait", 64'(done), 64'd1);
   endtask

   initial begin
      logic [7:0] two_word[$];
      logic [7:0] six[$];
      logic [7:0] full[$];
      logic [7:0] one[$];
      logic [7:0] b;
      logic [31:0] w;

      rst = 1'b0; start = 1'b0; load_len = 9'd0; byte_valid = 1'b0; byte_data = 8'd0;

      //            start len    bv    bd      rdy   we    addr     wdata          stl   pcr   dn    err   wl
      tbl[0]  = '{1'b1, 9'd2, 1'b0, 8'h00, 1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
      tbl[1]  = '{1'b0, 9'd0, 1'b1, 8'h80, 1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
      tbl[2]  = '{1'b0, 9'd0, 1'b1, 8'h20, 1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
      tbl[3]  = '{1'b1, 9'd5, 1'b1, 8'h00, 1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
      tbl[4]  = '{1'b0, 9'd0, 1'b1, 8'h0A, 1'b0, 1'b1, 10'h000, 32'h8020000A, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
      tbl[5]  = '{1'b0, 9'd0, 1'b1, 8'h04, 1'b1, 1'b0, 10'h000, 32'h8020000A, 1'b1, 1'b0, 1'b0, 1'b0, 9'd1};
      tbl[6]  = '{1'b0, 9'd0, 1'b1, 8'h04, 1'b1, 1'b0, 10'h000, 32'h8020000A, 1'b1, 1'b0, 1'b0, 1'b0, 9'd1};
      tbl[7]  = '{1'b0, 9'd0, 1'b1, 8'h40, 1'b1, 1'b0, 10'h000, 32'h8020000A, 1'b1, 1'b0, 1'b0, 1'b0, 9'd1};
      tbl[8]  = '{1'b0, 9'd0, 1'b1, 8'h08, 1'b1, 1'b0, 10'h000, 32'h8020000A, 1'b1, 1'b0, 1'b0, 1'b0, 9'd1};
      tbl[9]  = '{1'b0, 9'd0, 1'b1, 8'h00, 1'b0, 1'b1, 10'h004, 32'h04400800, 1'b1, 1'b0, 1'b0, 1'b0, 9'd1};
      tbl[10] = '{1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h004, 32'h04400800, 1'b1, 1'b1, 1'b0, 1'b0, 9'd2};
      tbl[11] = '{1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h004, 32'h04400800, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2};
      tbl[12] = '{1'b0, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h004, 32'h04400800, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2};
      tbl[13] = '{1'b0, 9'd0, 1'b1, 8'h55, 1'b0, 1'b0, 10'h004, 32'h04400800, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2};

      two_word = '{8'h80, 8'h20, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00};

      // Reset, then idle with start low.
      repeat (3) @(negedge clk);
      check("reset_outputs", outs(), 64'd0);
      rst = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("idle_outputs", outs(), 64'd0);
      end

      // Two-word load, cycle by cycle.
      for (int v = 0; v < 14; v++) begin
         start      = tbl[v].start;
         load_len   = tbl[v].len;
         byte_valid = tbl[v].bv;
         byte_data  = tbl[v].bd;
         @(negedge clk);
         check($sformatf("vec%0d", v), outs(), exp_of(tbl[v]));
      end
      start = 1'b0; byte_valid = 1'b0;

      // Throttled stream, started from RUN.
      clear_mon();
      do_start(9'd2);
      check("thr_start", {62'd0, byte_ready, done}, {62'd0, 1'b1, 1'b0});
      send_bytes(two_word, 1'b1, 200);
      wait_done(50);
      check("thr_nwr", 64'(wr_addr_q.size()), 64'd2);
      if (wr_addr_q.size() == 2) begin
         check("thr_w0", {wr_addr_q[0], wr_data_q[0]}, {10'h000, 32'h8020000A});
         check("thr_w1", {wr_addr_q[1], wr_data_q[1]}, {10'h004, 32'h04400800});
      end
      check("thr_we_rdy", 64'(we_rdy_cnt), 64'd0);
      check("thr_pcr", 64'(pcr_cnt), 64'd1);
      check("thr_end", {53'd0, fetch_stall, err, words_loaded}, {53'd0, 1'b0, 1'b0, 9'd2});

      // Bad length from IDLE, then zero length.
      #1 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      clear_mon();
      do_start(9'd257);
      check("bad_len", {60'd0, err, done, byte_ready, fetch_stall}, {60'd0, 4'b1000});
      repeat (5) @(negedge clk);
      check("bad_len_hold", {62'd0, err, fetch_stall}, {62'd0, 2'b10});
      do_start(9'd0);
      check("zero_finish", {61'd0, pc_reset, err, fetch_stall}, {61'd0, 3'b101});
      @(negedge clk);
      check("zero_run", {61'd0, pc_reset, done, fetch_stall}, {61'd0, 3'b010});
      @(negedge clk);
      check("zero_nwr", 64'(wr_addr_q.size()), 64'd0);
      check("zero_pcr", 64'(pcr_cnt), 64'd1);

      // Reset in the middle of a three-word load.
      clear_mon();
      six = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
      do_start(9'd3);
      send_bytes(six, 1'b0, 50);
      #1 rst = 1'b0;
      #1;
      check("midrst_outs", outs(), 64'd0);
      check("midrst_nwr", 64'(wr_addr_q.size()), 64'd1);
      if (wr_addr_q.size() == 1)
         check("midrst_w0", {wr_addr_q[0], wr_data_q[0]}, {10'h000, 32'hA1A2A3A4});
      check("midrst_pcr", 64'(pcr_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Full 256-word load.
      clear_mon();
      for (int i = 0; i < 256; i++) begin
         b = 8'(i);
         full.push_back(b);
         full.push_back(b ^ 8'hA5);
         full.push_back(~b);
         full.push_back(b + 8'd1);
      end
      do_start(9'd256);
      send_bytes(full, 1'b0, 3000);
      wait_done(20);
      check("full_nwr", 64'(wr_addr_q.size()), 64'd256);
      if (wr_addr_q.size() == 256) begin
         for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            w = {b, b ^ 8'hA5, ~b, b + 8'd1};
            check($sformatf("full_w%0d", i), {wr_addr_q[i], wr_data_q[i]}, {10'(i * 4), w});
         end
         check("full_last_addr", 64'(wr_addr_q[255]), 64'h3FC);
      end
      check("full_wl", 64'(words_loaded), 64'd256);
      check("full_pcr", 64'(pcr_cnt), 64'd1);

      // Reload from RUN.
      clear_mon();
      one = '{8'h10, 8'h20, 8'h30, 8'h40};
      do_start(9'd1);
      check("reload_start", {51'd0, done, fetch_stall, byte_ready, err, words_loaded},
            {51'd0, 4'b0110, 9'd0});
      send_bytes(one, 1'b0, 50);
      wait_done(20);
      check("reload_nwr", 64'(wr_addr_q.size()), 64'd1);
      if (wr_addr_q.size() == 1)
         check("reload_w0", {wr_addr_q[0], wr_data_q[0]}, {10'h000, 32'h10203040});
      check("reload_pcr", 64'(pcr_cnt), 64'd1);
      check("reload_end", {53'd0, fetch_stall, done, words_loaded}, {53'd0, 2'b01, 9'd1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
